// File: rtl/markov_transition_counter_if.sv
// Note-stream handshake between a note source (master) and the transition counter (slave).
interface markov_transition_counter_if #(
    parameter int unsigned NOTE_W = 7
);
    logic              note_valid;
    logic [NOTE_W-1:0] note_data;
    logic              note_last;
    logic              note_ready;

    modport master (output note_valid, output note_data, output note_last, input note_ready);
    modport slave  (input note_valid, input note_data, input note_last, output note_ready);
endinterface

// File: rtl/markov_transition_counter.sv
// First-order Markov transition counter: folds a note stream into a table of
// unique (prev, next, count) entries, kept in first-occurrence order.
module markov_transition_counter #(
    parameter int unsigned NOTE_W = 7,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    markov_transition_counter_if.slave note,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W:0]            entry_count,
    output logic                       overflow,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [NOTE_W-1:0]          rd_prev,
    output logic [NOTE_W-1:0]          rd_next,
    output logic [CNT_W-1:0]           rd_count
);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_NOTE,
        S_SEARCH,
        S_INCREMENT,
        S_APPEND,
        S_FINISH
    } state_t;

    state_t state, state_d;

    logic [NOTE_W-1:0] prev_mem [DEPTH];
    logic [NOTE_W-1:0] next_mem [DEPTH];
    logic [CNT_W-1:0]  cnt_mem  [DEPTH];

    logic [NOTE_W-1:0] prev_reg;
    logic [NOTE_W-1:0] cur_reg;
    logic              last_reg;
    logic              has_prev;
    logic [ADDR_W:0]   idx;

    logic              xfer;
    logic              start_go;
    logic              at_end;
    logic              match;
    logic              full;
    logic [ADDR_W-1:0] idx_a;
    logic [ADDR_W-1:0] wr_a;

    assign xfer     = note.note_valid && (state == S_WAIT_NOTE);
    assign start_go = start && ((state == S_IDLE) || (state == S_FINISH));
    assign idx_a    = idx[ADDR_W-1:0];
    assign wr_a     = entry_count[ADDR_W-1:0];
    assign at_end   = (idx == entry_count);
    assign full     = (entry_count == FULL);
    assign match    = !at_end && (prev_mem[idx_a] == prev_reg) && (next_mem[idx_a] == cur_reg);

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:      if (start_go) state_d = S_WAIT_NOTE;
            S_WAIT_NOTE: begin
                if (xfer) begin
                    if (has_prev)            state_d = S_SEARCH;
                    else if (note.note_last) state_d = S_FINISH;
                end
            end
            S_SEARCH: begin
                if (at_end)     state_d = S_APPEND;
                else if (match) state_d = S_INCREMENT;
            end
            S_INCREMENT,
            S_APPEND:    state_d = last_reg ? S_FINISH : S_WAIT_NOTE;
            S_FINISH:    if (start_go) state_d = S_WAIT_NOTE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register; status outputs are registered decodes of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            note.note_ready <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_d;
            note.note_ready <= (state_d == S_WAIT_NOTE);
            busy            <= (state_d != S_IDLE) && (state_d != S_FINISH);
            done            <= (state_d == S_FINISH);
        end
    end

    // Pass control and search datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_count <= '0;
            overflow    <= 1'b0;
            has_prev    <= 1'b0;
            prev_reg    <= '0;
            cur_reg     <= '0;
            last_reg    <= 1'b0;
            idx         <= '0;
        end else begin
            if (start_go) begin
                entry_count <= '0;
                overflow    <= 1'b0;
                has_prev    <= 1'b0;
            end
            case (state)
                S_WAIT_NOTE: begin
                    if (xfer && !has_prev) begin
                        prev_reg <= note.note_data;
                        has_prev <= 1'b1;
                    end else if (xfer) begin
                        cur_reg  <= note.note_data;
                        last_reg <= note.note_last;
                        idx      <= '0;
                    end
                end
                S_SEARCH: if (!at_end && !match) idx <= idx + (ADDR_W+1)'(1);
                S_INCREMENT: prev_reg <= cur_reg;
                S_APPEND: begin
                    prev_reg <= cur_reg;
                    if (full) overflow    <= 1'b1;
                    else      entry_count <= entry_count + (ADDR_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Table storage; rows at or above entry_count are don't-care, so no reset
    always_ff @(posedge clk) begin
        if ((state == S_INCREMENT) && (cnt_mem[idx_a] != CNT_MAX)) begin
            cnt_mem[idx_a] <= cnt_mem[idx_a] + CNT_W'(1);
        end
        if ((state == S_APPEND) && !full) begin
            prev_mem[wr_a] <= prev_reg;
            next_mem[wr_a] <= cur_reg;
            cnt_mem[wr_a]  <= CNT_W'(1);
        end
    end

    assign rd_prev  = prev_mem[rd_addr];
    assign rd_next  = next_mem[rd_addr];
    assign rd_count = cnt_mem[rd_addr];

endmodule

// File: tb/tb_markov_transition_counter.sv
// Self-checking bench: a 64-entry instance (a) and a 4-entry instance (b)
// compared against a list-based transition model.
module tb_markov_transition_counter;
    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    logic busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [6:0] cnt_a;
    logic [2:0] cnt_b;
    logic [5:0] rd_addr_a;
    logic [1:0] rd_addr_b;
    logic [6:0] rp_a, rn_a, rp_b, rn_b;
    logic [7:0] rc_a, rc_b;

    int total = 0;
    int bad   = 0;

    markov_transition_counter_if #(.NOTE_W(7)) nif_a ();
    markov_transition_counter_if #(.NOTE_W(7)) nif_b ();

    markov_transition_counter #(.NOTE_W(7), .CNT_W(8), .DEPTH(64), .ADDR_W(6)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .note(nif_a.slave),
        .busy(busy_a), .done(done_a), .entry_count(cnt_a), .overflow(ovf_a),
        .rd_addr(rd_addr_a), .rd_prev(rp_a), .rd_next(rn_a), .rd_count(rc_a));

    markov_transition_counter #(.NOTE_W(7), .CNT_W(8), .DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .note(nif_b.slave),
        .busy(busy_b), .done(done_b), .entry_count(cnt_b), .overflow(ovf_b),
        .rd_addr(rd_addr_b), .rd_prev(rp_b), .rd_next(rn_b), .rd_count(rc_b));

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] seq[$];
    int m_prev[64], m_next[64], m_cnt[64];
    int m_n;
    int m_ovf;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int depth);
        int found;
        m_n = 0;
        m_ovf = 0;
        for (int i = 1; i < seq.size(); i++) begin
            found = -1;
            for (int k = 0; k < m_n; k++)
                if (found < 0 && m_prev[k] == int'(seq[i-1]) && m_next[k] == int'(seq[i])) found = k;
            if (found >= 0) begin
                if (m_cnt[found] < 255) m_cnt[found]++;
            end else if (m_n == depth) begin
                m_ovf = 1;
            end else begin
                m_prev[m_n] = int'(seq[i-1]);
                m_next[m_n] = int'(seq[i]);
                m_cnt[m_n]  = 1;
                m_n++;
            end
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? nif_a.note_ready : nif_b.note_ready;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    task automatic set_note(input int sel, input logic v, input logic [6:0] d, input logic l);
        if (sel == 0) begin nif_a.note_valid = v; nif_a.note_data = d; nif_a.note_last = l; end
        else          begin nif_b.note_valid = v; nif_b.note_data = d; nif_b.note_last = l; end
    endtask

    // Entered and left at a falling edge
    task automatic pulse_start(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_note(input int sel, input logic [6:0] d, input logic l);
        int n = 0;
        set_note(sel, 1'b1, d, l);
        while (!get_ready(sel) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("ready_timeout", int'(get_ready(sel)), 1);
        @(posedge clk);
        @(negedge clk);
        set_note(sel, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic wait_done(input int sel, input int budget, input string tag);
        int n = 0;
        while (!get_done(sel) && n < budget) begin @(negedge clk); n++; end
        chk({tag, ".done"}, int'(get_done(sel)), 1);
    endtask

    task automatic check_tables(input int sel, input string tag);
        chk({tag, ".entry_count"}, (sel == 0) ? int'(cnt_a) : int'(cnt_b), m_n);
        chk({tag, ".overflow"},    (sel == 0) ? int'(ovf_a) : int'(ovf_b), m_ovf);
        chk({tag, ".busy"},        (sel == 0) ? int'(busy_a) : int'(busy_b), 0);
        for (int k = 0; k < m_n; k++) begin
            if (sel == 0) rd_addr_a = 6'(k); else rd_addr_b = 2'(k);
            #1;
            chk($sformatf("%s.prev[%0d]", tag, k),  (sel == 0) ? int'(rp_a) : int'(rp_b), m_prev[k]);
            chk($sformatf("%s.next[%0d]", tag, k),  (sel == 0) ? int'(rn_a) : int'(rn_b), m_next[k]);
            chk($sformatf("%s.count[%0d]", tag, k), (sel == 0) ? int'(rc_a) : int'(rc_b), m_cnt[k]);
        end
    endtask

    task automatic run_seq(input int sel, input string tag);
        pulse_start(sel);
        for (int i = 0; i < seq.size(); i++) send_note(sel, seq[i], (i == seq.size() - 1));
        wait_done(sel, 200, tag);
        model((sel == 0) ? 64 : 4);
        check_tables(sel, tag);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        set_note(0, 1'b0, 7'd0, 1'b0);
        set_note(1, 1'b0, 7'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst.ready_a", int'(nif_a.note_ready), 0);
        chk("rst.busy_a",  int'(busy_a), 0);
        chk("rst.done_a",  int'(done_a), 0);
        chk("rst.count_a", int'(cnt_a), 0);
        chk("rst.ovf_b",   int'(ovf_b), 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic pass, with a start pulse ignored while busy
        seq = '{7'd60, 7'd62, 7'd60, 7'd62};
        pulse_start(0);
        send_note(0, 7'd60, 1'b0);
        send_note(0, 7'd62, 1'b0);
        chk("basic.busy_mid", int'(busy_a), 1);
        pulse_start(0);
        send_note(0, 7'd60, 1'b0);
        send_note(0, 7'd62, 1'b1);
        wait_done(0, 50, "basic");
        model(64);
        check_tables(0, "basic");
        chk("basic.m_count0", m_cnt[0], 2);

        // Single note with last: FINISH straight from the transfer
        pulse_start(0);
        send_note(0, 7'd45, 1'b1);
        n = 0;
        while (!done_a && n < 1) begin @(negedge clk); n++; end
        chk("single.done",  int'(done_a), 1);
        chk("single.count", int'(cnt_a), 0);

        // Saturation
        seq.delete();
        for (int i = 0; i < 521; i++) seq.push_back((i % 2 == 0) ? 7'd1 : 7'd2);
        run_seq(0, "sat");

        // Overflow on the 4-entry instance
        seq = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6};
        run_seq(1, "ovf");

        // Backpressure: third entry matches, note held valid through the search
        pulse_start(0);
        send_note(0, 7'd10, 1'b0);
        send_note(0, 7'd11, 1'b0);
        send_note(0, 7'd12, 1'b0);
        send_note(0, 7'd12, 1'b0);
        set_note(0, 1'b1, 7'd12, 1'b0);
        n = 0;
        while (!nif_a.note_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        set_note(0, 1'b1, 7'd30, 1'b1);
        n = 0;
        while (!nif_a.note_ready && n < 20) begin @(negedge clk); n++; end
        chk("bp.ready_low_cycles", n, 4);
        @(posedge clk);
        @(negedge clk);
        set_note(0, 1'b0, 7'd0, 1'b0);
        wait_done(0, 50, "bp");
        seq = '{7'd10, 7'd11, 7'd12, 7'd12, 7'd12, 7'd30};
        model(64);
        check_tables(0, "bp");

        // Reset during SEARCH, then a fresh pass
        pulse_start(0);
        send_note(0, 7'd1, 1'b0);
        send_note(0, 7'd2, 1'b0);
        send_note(0, 7'd3, 1'b0);
        send_note(0, 7'd4, 1'b0);
        send_note(0, 7'd5, 1'b0);
        chk("rr.in_search_busy",  int'(busy_a), 1);
        chk("rr.in_search_ready", int'(nif_a.note_ready), 0);
        reset = 1'b0;
        #1;
        chk("rr.ready", int'(nif_a.note_ready), 0);
        chk("rr.busy",  int'(busy_a), 0);
        chk("rr.done",  int'(done_a), 0);
        chk("rr.ovf",   int'(ovf_a), 0);
        chk("rr.count", int'(cnt_a), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rr.idle_busy", int'(busy_a), 0);
        chk("rr.idle_done", int'(done_a), 0);
        seq = '{7'd7, 7'd7};
        run_seq(0, "rr");

        // Randomized passes on both instances
        for (int r = 0; r < 24; r++) begin
            int sel, len;
            sel = r % 2;
            len = int'($urandom_range(1, 40));
            seq.delete();
            for (int i = 0; i < len; i++)
                seq.push_back(7'((sel == 0) ? $urandom_range(0, 5) : $urandom_range(0, 9)));
            run_seq(sel, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
